// File: rtl/memory_pkg.sv
// Shared types for the memory request front-end: memory read flavour, FSM states
// and the buffered request record.
package memory_pkg;

    typedef enum logic {
        ASYNC_READ = 1'b0,
        SYNC_READ  = 1'b1
    } read_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RSP  = 2'd2
    } fsm_t;

    // req_t is sized by these; front-end width parameters default to them.
    localparam int unsigned REQ_ADDR_WIDTH = 8;
    localparam int unsigned REQ_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      write;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] data;
    } req_t;

endpackage

// File: rtl/memory_req_fifo.sv
// Request FIFO with a separate occupancy counter; a same-cycle pop never frees a slot
// for the push, so there is no full pass-through.
module memory_req_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned REQ_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_push,
    input  logic [1+ADDR_WIDTH+DATA_WIDTH-1:0] i_data,
    input  logic                               i_pop,
    output logic [1+ADDR_WIDTH+DATA_WIDTH-1:0] o_head,
    output logic                               o_full,
    output logic                               o_empty
);

    localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned PTR_W   = $clog2(REQ_DEPTH);

    logic [ENTRY_W-1:0] r_mem [REQ_DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(REQ_DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/memory_req_frontend.sv
// Buffers read/write requests and serialises them onto the memory port, one op per
// cycle; the read address parks whenever no read is issued.
module memory_req_frontend
    import memory_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH = REQ_DATA_WIDTH,
    parameter int unsigned              ADDR_WIDTH = REQ_ADDR_WIDTH,
    parameter int unsigned              REQ_DEPTH  = 4,
    parameter read_type_t               MEM_TYPE   = ASYNC_READ,
    parameter logic [ADDR_WIDTH-1:0]    PARK_ADDR  = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    fsm_t                  r_state;
    fsm_t                  w_state_next;
    req_t                  w_req;
    req_t                  w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_issue_wr;
    logic                  w_issue_rd;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    assign w_req = '{write: req_write, addr: req_addr, data: req_data};

    memory_req_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REQ_DEPTH  (REQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_valid),
        .i_data  (w_req),
        .i_pop   (w_issue_wr || w_issue_rd),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign req_ready = !w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue_rd) begin
                    w_state_next = (MEM_TYPE == SYNC_READ) ? WAIT : RSP;
                end
            end
            WAIT:    w_state_next = RSP;
            RSP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Writes drain even while a response is held; reads need an idle response slot.
    always_comb begin
        w_issue_wr = 1'b0;
        w_issue_rd = 1'b0;
        if (!w_empty && r_state != WAIT) begin
            if (w_head.write) begin
                w_issue_wr = 1'b1;
            end else if (r_state == IDLE) begin
                w_issue_rd = 1'b1;
            end
        end
        mem_write_en   = w_issue_wr;
        mem_write_addr = w_issue_wr ? w_head.addr : '0;
        mem_write_data = w_issue_wr ? w_head.data : '0;
        mem_read_addr  = w_issue_rd ? w_head.addr : PARK_ADDR;
        rsp_valid      = (r_state == RSP);
    end

    assign w_capture = (r_state == WAIT) ||
                       (w_issue_rd && MEM_TYPE == ASYNC_READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data <= '0;
        end else if (w_capture) begin
            r_rsp_data <= mem_read_data;
        end
    end

    assign rsp_data = r_rsp_data;

`ifndef SYNTHESIS
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        req_valid && !req_ready |=> req_valid && $stable(req_write) &&
        $stable(req_addr) && $stable(req_data));

    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_data));

    a_read_park: assert property (@(posedge clk) disable iff (rst)
        !w_issue_rd |-> mem_read_addr == PARK_ADDR);
`endif

endmodule

// File: tb/tb_memory_req_frontend.sv
// Directed bench: one async-read and one sync-read front-end, each with its own
// behavioural memory.
module tb_memory_req_frontend;
    import memory_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          a_rst, a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready;
    logic [AW-1:0] a_req_addr, a_mem_waddr, a_mem_raddr;
    logic [DW-1:0] a_req_data, a_rsp_data, a_mem_wdata, a_mem_rdata;
    logic          a_mem_we;
    logic          s_rst, s_req_valid, s_req_ready, s_req_write, s_rsp_valid, s_rsp_ready;
    logic [AW-1:0] s_req_addr, s_mem_waddr, s_mem_raddr;
    logic [DW-1:0] s_req_data, s_rsp_data, s_mem_wdata, s_mem_rdata;
    logic          s_mem_we;

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_s [256];

    assign a_mem_rdata = mem_a[a_mem_raddr];

    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_waddr] <= a_mem_wdata;
        if (s_mem_we) mem_s[s_mem_waddr] <= s_mem_wdata;
        s_mem_rdata <= mem_s[s_mem_raddr];
    end

    memory_req_frontend #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .REQ_DEPTH  (4),
        .MEM_TYPE   (ASYNC_READ),
        .PARK_ADDR  (8'hFF)
    ) u_dut_a (
        .clk            (clk),
        .rst            (a_rst),
        .req_valid      (a_req_valid),
        .req_ready      (a_req_ready),
        .req_write      (a_req_write),
        .req_addr       (a_req_addr),
        .req_data       (a_req_data),
        .rsp_valid      (a_rsp_valid),
        .rsp_ready      (a_rsp_ready),
        .rsp_data       (a_rsp_data),
        .mem_write_en   (a_mem_we),
        .mem_write_addr (a_mem_waddr),
        .mem_write_data (a_mem_wdata),
        .mem_read_addr  (a_mem_raddr),
        .mem_read_data  (a_mem_rdata)
    );

    memory_req_frontend #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .REQ_DEPTH  (4),
        .MEM_TYPE   (SYNC_READ),
        .PARK_ADDR  (8'hFF)
    ) u_dut_s (
        .clk            (clk),
        .rst            (s_rst),
        .req_valid      (s_req_valid),
        .req_ready      (s_req_ready),
        .req_write      (s_req_write),
        .req_addr       (s_req_addr),
        .req_data       (s_req_data),
        .rsp_valid      (s_rsp_valid),
        .rsp_ready      (s_rsp_ready),
        .rsp_data       (s_rsp_data),
        .mem_write_en   (s_mem_we),
        .mem_write_addr (s_mem_waddr),
        .mem_write_data (s_mem_wdata),
        .mem_read_addr  (s_mem_raddr),
        .mem_read_data  (s_mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle right after the request handshake.
    task automatic a_send(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        int n;
        n = 0;
        a_req_valid = 1'b1; a_req_write = w; a_req_addr = ad; a_req_data = d;
        while (a_req_ready !== 1'b1 && n < 20) begin tick(); n++; end
        total++;
        if (a_req_ready !== 1'b1) begin
            bad++; $display("FAIL a_send_timeout: got ready=%b want 1", a_req_ready);
        end
        tick();
        a_req_valid = 1'b0;
    endtask

    task automatic s_send(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        int n;
        n = 0;
        s_req_valid = 1'b1; s_req_write = w; s_req_addr = ad; s_req_data = d;
        while (s_req_ready !== 1'b1 && n < 20) begin tick(); n++; end
        total++;
        if (s_req_ready !== 1'b1) begin
            bad++; $display("FAIL s_send_timeout: got ready=%b want 1", s_req_ready);
        end
        tick();
        s_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; s_rst = 1'b1;
        tick(); tick();
        total++; if (a_req_ready !== 1'b1) begin
            bad++; $display("FAIL rst_req_ready: got %b want 1", a_req_ready); end
        total++; if (a_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_rsp_valid: got %b want 0", a_rsp_valid); end
        total++; if (a_rsp_data !== 32'h0) begin
            bad++; $display("FAIL rst_rsp_data: got %h want 0", a_rsp_data); end
        total++; if ({a_mem_we, a_mem_waddr, a_mem_wdata} !== 41'h0) begin
            bad++; $display("FAIL rst_mem_write: got %b/%h/%h want 0/00/0",
                            a_mem_we, a_mem_waddr, a_mem_wdata); end
        total++; if (a_mem_raddr !== 8'hFF) begin
            bad++; $display("FAIL rst_read_addr: got %h want ff", a_mem_raddr); end
        total++; if ({s_req_ready, s_rsp_valid, s_mem_we, s_mem_raddr} !== {3'b100, 8'hFF}) begin
            bad++; $display("FAIL rst_sync_outputs: got %b%b%b/%h want 100/ff",
                            s_req_ready, s_rsp_valid, s_mem_we, s_mem_raddr); end
        a_rst = 1'b0; s_rst = 1'b0;
    endtask

    task automatic test_async_wr_rd();
        a_send(1'b1, 8'h0A, 32'hDEADBEEF);
        total++; if ({a_mem_we, a_mem_waddr, a_mem_wdata} !== {1'b1, 8'h0A, 32'hDEADBEEF}) begin
            bad++; $display("FAIL async_write_issue: got %b/%h/%h want 1/0a/deadbeef",
                            a_mem_we, a_mem_waddr, a_mem_wdata); end
        a_send(1'b0, 8'h0A, 32'h0);
        total++; if ({a_mem_we, a_mem_raddr, a_rsp_valid} !== {1'b0, 8'h0A, 1'b0}) begin
            bad++; $display("FAIL async_read_issue: got we=%b ra=%h rv=%b want 0/0a/0",
                            a_mem_we, a_mem_raddr, a_rsp_valid); end
        tick();
        total++; if ({a_rsp_valid, a_rsp_data} !== {1'b1, 32'hDEADBEEF}) begin
            bad++; $display("FAIL async_read_rsp: got %b/%h want 1/deadbeef",
                            a_rsp_valid, a_rsp_data); end
        tick();
        total++; if (a_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL async_rsp_clear: got %b want 0", a_rsp_valid); end
    endtask

    task automatic test_fill();
        a_rsp_ready = 1'b0;
        a_send(1'b0, 8'h0A, 32'h0);
        tick();
        total++; if ({a_rsp_valid, a_rsp_data} !== {1'b1, 32'hDEADBEEF}) begin
            bad++; $display("FAIL fill_held_rsp: got %b/%h want 1/deadbeef",
                            a_rsp_valid, a_rsp_data); end
        a_send(1'b0, 8'h0A, 32'h0);
        a_send(1'b1, 8'h20, 32'h2000_0020);
        a_send(1'b1, 8'h21, 32'h2000_0021);
        a_send(1'b1, 8'h22, 32'h2000_0022);
        total++; if ({a_req_ready, a_mem_we} !== 2'b00) begin
            bad++; $display("FAIL fill_full: got ready=%b we=%b want 0/0", a_req_ready, a_mem_we);
        end
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h23; a_req_data = 32'h2000_0023;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({a_req_ready, a_mem_we, a_rsp_data} !== {2'b00, 32'hDEADBEEF}) begin
                bad++; $display("FAIL fill_hold_%0d: got ready=%b we=%b rd=%h want 0/0/deadbeef",
                                i, a_req_ready, a_mem_we, a_rsp_data); end
        end
        a_rsp_ready = 1'b1;
        tick();
        total++; if ({a_req_ready, a_mem_we, a_mem_raddr} !== {2'b00, 8'h0A}) begin
            bad++; $display("FAIL fill_read2_issue: got ready=%b we=%b ra=%h want 0/0/0a",
                            a_req_ready, a_mem_we, a_mem_raddr); end
        tick();
        total++; if ({a_rsp_valid, a_req_ready, a_mem_we, a_mem_waddr} !== {3'b111, 8'h20}) begin
            bad++; $display("FAIL fill_drain0: got rv=%b ready=%b we=%b wa=%h want 1/1/1/20",
                            a_rsp_valid, a_req_ready, a_mem_we, a_mem_waddr); end
        tick();
        a_req_valid = 1'b0;
        total++; if ({a_mem_we, a_mem_waddr} !== {1'b1, 8'h21}) begin
            bad++; $display("FAIL fill_drain1: got %b/%h want 1/21", a_mem_we, a_mem_waddr); end
        tick();
        total++; if ({a_mem_we, a_mem_waddr} !== {1'b1, 8'h22}) begin
            bad++; $display("FAIL fill_drain2: got %b/%h want 1/22", a_mem_we, a_mem_waddr); end
        tick();
        total++; if ({a_mem_we, a_mem_waddr, a_mem_wdata} !== {1'b1, 8'h23, 32'h2000_0023}) begin
            bad++; $display("FAIL fill_drain3: got %b/%h/%h want 1/23/20000023",
                            a_mem_we, a_mem_waddr, a_mem_wdata); end
        tick();
        total++; if ({a_mem_we, a_req_ready} !== 2'b01) begin
            bad++; $display("FAIL fill_empty: got we=%b ready=%b want 0/1", a_mem_we, a_req_ready);
        end
    endtask

    task automatic test_backpressure();
        a_send(1'b1, 8'h05, 32'h5555_AAAA);
        a_send(1'b1, 8'h06, 32'h6666_BBBB);
        tick(); tick();
        a_rsp_ready = 1'b0;
        a_send(1'b0, 8'h05, 32'h0);
        a_send(1'b0, 8'h06, 32'h0);
        for (int i = 0; i < 5; i++) begin
            total++; if ({a_rsp_valid, a_rsp_data, a_mem_raddr} !== {1'b1, 32'h5555_AAAA, 8'hFF})
            begin
                bad++; $display("FAIL bp_hold_%0d: got %b/%h/%h want 1/5555aaaa/ff",
                                i, a_rsp_valid, a_rsp_data, a_mem_raddr); end
            tick();
        end
        a_rsp_ready = 1'b1;
        tick();
        total++; if ({a_rsp_valid, a_mem_raddr} !== {1'b0, 8'h06}) begin
            bad++; $display("FAIL bp_second_issue: got %b/%h want 0/06", a_rsp_valid, a_mem_raddr);
        end
        tick();
        total++; if ({a_rsp_valid, a_rsp_data} !== {1'b1, 32'h6666_BBBB}) begin
            bad++; $display("FAIL bp_second_rsp: got %b/%h want 1/6666bbbb",
                            a_rsp_valid, a_rsp_data); end
        tick();
        total++; if (a_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_rsp_clear: got %b want 0", a_rsp_valid); end
    endtask

    task automatic test_idle_park();
        a_send(1'b1, 8'h0A, 32'hDEADBEEF);
        tick();
        for (int i = 0; i < 10; i++) begin
            total++; if ({a_mem_we, a_mem_raddr} !== {1'b0, 8'hFF}) begin
                bad++; $display("FAIL park_%0d: got we=%b ra=%h want 0/ff", i, a_mem_we, a_mem_raddr);
            end
            tick();
        end
        a_send(1'b0, 8'h0A, 32'h0);
        tick();
        total++; if ({a_rsp_valid, a_rsp_data} !== {1'b1, 32'hDEADBEEF}) begin
            bad++; $display("FAIL park_readback: got %b/%h want 1/deadbeef",
                            a_rsp_valid, a_rsp_data); end
        tick();
    endtask

    task automatic test_sync_wr_rd();
        s_send(1'b1, 8'h0A, 32'hDEADBEEF);
        total++; if ({s_mem_we, s_mem_waddr, s_mem_wdata} !== {1'b1, 8'h0A, 32'hDEADBEEF}) begin
            bad++; $display("FAIL sync_write_issue: got %b/%h/%h want 1/0a/deadbeef",
                            s_mem_we, s_mem_waddr, s_mem_wdata); end
        s_send(1'b0, 8'h0A, 32'h0);
        total++; if ({s_mem_we, s_mem_raddr, s_rsp_valid} !== {1'b0, 8'h0A, 1'b0}) begin
            bad++; $display("FAIL sync_read_issue: got %b/%h/%b want 0/0a/0",
                            s_mem_we, s_mem_raddr, s_rsp_valid); end
        tick();
        total++; if ({s_mem_we, s_mem_raddr, s_rsp_valid} !== {1'b0, 8'hFF, 1'b0}) begin
            bad++; $display("FAIL sync_wait_quiet: got %b/%h/%b want 0/ff/0",
                            s_mem_we, s_mem_raddr, s_rsp_valid); end
        tick();
        total++; if ({s_rsp_valid, s_rsp_data} !== {1'b1, 32'hDEADBEEF}) begin
            bad++; $display("FAIL sync_read_rsp: got %b/%h want 1/deadbeef",
                            s_rsp_valid, s_rsp_data); end
        tick();
        total++; if (s_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL sync_rsp_clear: got %b want 0", s_rsp_valid); end
    endtask

    task automatic test_reset_in_wait();
        s_rsp_ready = 1'b0;
        s_send(1'b0, 8'h0A, 32'h0);
        tick(); tick();
        s_send(1'b0, 8'h0A, 32'h0);
        s_send(1'b1, 8'h30, 32'h3000_0030);
        s_send(1'b1, 8'h31, 32'h3000_0031);
        total++; if ({s_rsp_valid, s_mem_we} !== 2'b10) begin
            bad++; $display("FAIL rw_queued: got rv=%b we=%b want 1/0", s_rsp_valid, s_mem_we); end
        s_rsp_ready = 1'b1;
        tick();
        total++; if (s_mem_raddr !== 8'h0A) begin
            bad++; $display("FAIL rw_read2_issue: got %h want 0a", s_mem_raddr); end
        tick();
        total++; if ({s_mem_we, s_mem_raddr, s_rsp_valid} !== {1'b0, 8'hFF, 1'b0}) begin
            bad++; $display("FAIL rw_in_wait: got %b/%h/%b want 0/ff/0",
                            s_mem_we, s_mem_raddr, s_rsp_valid); end
        s_rst = 1'b1;
        tick();
        total++; if ({s_rsp_valid, s_req_ready, s_mem_we, s_mem_raddr, s_rsp_data} !==
                     {3'b010, 8'hFF, 32'h0}) begin
            bad++; $display("FAIL rw_after_rst: got rv=%b rdy=%b we=%b ra=%h rd=%h want 0/1/0/ff/0",
                            s_rsp_valid, s_req_ready, s_mem_we, s_mem_raddr, s_rsp_data); end
        s_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({s_rsp_valid, s_mem_we, s_mem_raddr} !== {2'b00, 8'hFF}) begin
                bad++; $display("FAIL rw_flushed_%0d: got rv=%b we=%b ra=%h want 0/0/ff",
                                i, s_rsp_valid, s_mem_we, s_mem_raddr); end
        end
        s_send(1'b0, 8'h0A, 32'h0);
        tick(); tick();
        total++; if ({s_rsp_valid, s_rsp_data} !== {1'b1, 32'hDEADBEEF}) begin
            bad++; $display("FAIL rw_fresh_read: got %b/%h want 1/deadbeef",
                            s_rsp_valid, s_rsp_data); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0;
        a_req_data = '0; a_rsp_ready = 1'b1;
        s_rst = 1'b1; s_req_valid = 1'b0; s_req_write = 1'b0; s_req_addr = '0;
        s_req_data = '0; s_rsp_ready = 1'b1;
        test_reset();
        test_async_wr_rd();
        test_fill();
        test_backpressure();
        test_idle_park();
        test_sync_wr_rd();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_req_frontend.md
Name: memory_req_frontend

Overview:
- Request front-end that sits directly upstream of the memory abstraction and drives its write/read port.
- Accepts read and write requests on a valid/ready interface and buffers them in a small FIFO.
- Serialises them into one memory operation per cycle and returns read data on a valid/ready response channel.
- Shields the memory from spurious "non-write" cycles: any non-write cycle whose read address matches a stored entry consumes that entry, so idle cycles must not present a live read address.

Parameters:
DATA_WIDTH, 32, data width of requests, responses and memory data.
ADDR_WIDTH, 8, memory address width.
REQ_DEPTH, 4, request FIFO depth; power of 2, minimum 2.
MEM_TYPE, ASYNC_READ, read_type_t of the attached memory; selects read latency 0 (ASYNC_READ) or 1 (SYNC_READ).
PARK_ADDR, '1, address driven on mem_read_addr whenever no read is being issued; software never writes this address.

Ports:
clk  input  1  single clock; also drives the memory's wr_clk and rd_clk.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  FIFO can accept a request.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  request address.
req_data  input  DATA_WIDTH  write data; ignored for reads.
rsp_valid  output  1  read response present.
rsp_ready  input  1  consumer accepts the response.
rsp_data  output  DATA_WIDTH  read data.
mem_write_en  output  1  to memory write_en.
mem_write_addr  output  ADDR_WIDTH  to memory write_addr.
mem_write_data  output  DATA_WIDTH  to memory write_data.
mem_read_addr  output  ADDR_WIDTH  to memory read_addr.
mem_read_data  input  DATA_WIDTH  from memory read_data.

Behaviour:
- Reset (synchronous, active-high): FIFO empty; FSM to IDLE.
  - Outputs after reset: req_ready=1, rsp_valid=0, rsp_data=0, mem_write_en=0, mem_write_addr=0, mem_write_data=0, mem_read_addr=PARK_ADDR.
- Request FIFO:
  - Push when req_valid && req_ready; req_ready = !full.
  - A pop in the same cycle does not free a slot for the push, so there is no full-pass-through.
  - Pointers are log2(REQ_DEPTH)+1 bits; wrap is modulo REQ_DEPTH.
  - Count is held in a separate register, 0..REQ_DEPTH.
- Issue stage, combinational from the FIFO head and FSM state. Each cycle it issues at most one operation.
  - Write at head: always issued. mem_write_en=1, mem_write_addr/data = head fields, pop. No response is generated.
  - Read at head, allowed only in IDLE with rsp_valid=0: mem_write_en=0, mem_read_addr=head addr, pop.
  - Read at head when not allowed: head stalls and the FIFO holds.
  - Otherwise (no issue): mem_write_en=0, mem_read_addr=PARK_ADDR.
- FSM states and transitions:
  - IDLE: on a read issue with ASYNC_READ, capture mem_read_data into rsp_data the same cycle, set rsp_valid next cycle, go to RSP. On a read issue with SYNC_READ, go to WAIT.
  - WAIT (SYNC_READ only): no issue of any kind; mem_read_addr=PARK_ADDR. Capture mem_read_data, set rsp_valid, go to RSP.
  - RSP: rsp_valid=1 and rsp_data held stable until rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE. Writes may still issue while in RSP; reads stall.
- Latency with an empty FIFO, counted from the request handshake:
  - Write: reaches the memory 1 cycle later.
  - Read: rsp_valid asserts 2 cycles later (ASYNC_READ) or 3 cycles later (SYNC_READ).
- Ordering: strict FIFO order. A read never overtakes an earlier write to any address.
- Reset mid-operation: any pending WAIT capture and any held response are discarded; FIFO contents are dropped.
- Assertions:
  - req_* must be stable while req_valid && !req_ready.
  - rsp_data must be stable while rsp_valid && !rsp_ready.
  - mem_read_addr == PARK_ADDR whenever no read is issued.

Decomposition:
- Package memory_pkg: existing read_type_t; add the fsm enum {IDLE, WAIT, RSP} and a packed req_t {write, addr, data}.
- One sub-module: memory_req_fifo (parameterised on DATA_WIDTH, ADDR_WIDTH, REQ_DEPTH; push/pop/full/empty/head ports).

Test Plan:
- ASYNC_READ: write addr 0x0A data 0xDEADBEEF, then read 0x0A → mem_write_en pulse 1 cycle after the write handshake; rsp_valid 2 cycles after the read handshake with rsp_data=0xDEADBEEF.
- SYNC_READ, same sequence → rsp_valid 3 cycles after the read handshake with rsp_data=0xDEADBEEF; no memory op issued during WAIT.
- Fill FIFO with 4 writes while a response is held (rsp_ready=0) → req_ready drops after the 4th push, the 5th req_valid is held, and all 4 writes drain in order.
- Read 0x05 with rsp_ready=0 for 5 cycles, followed by a read 0x06 → rsp_data for 0x05 stable for 5 cycles; the 0x06 read issues only after the first response is accepted.
- Idle 10 cycles after a write to 0x0A → mem_read_addr=PARK_ADDR throughout; a subsequent read of 0x0A returns 0xDEADBEEF.
- Assert rst while in WAIT with 2 queued requests → next cycle rsp_valid=0, req_ready=1, FIFO empty, no memory op issued.
